// File: rtl/piso_vector.sv
// Parallel-in, serial-out pixel serializer: one packed vector in, NUM_PIX pixels out on a valid/ready stream.
// Latency: a vector accepted at edge N has its first pixel valid after edge N; one pixel per cycle after that.
// Backpressure: pixel, last flag and count hold while i_ready is low. o_ready is only high when idle or on an accepted final beat.
// Emission order is highest-index pixel first. Defining PISO_VECTOR_LSB_FIRST_EN switches it to pixel 0 first.
module piso_vector #(
    parameter int NUM_PIX = 5,
    parameter int PIX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_PIX*PIX_W-1:0] i_vector,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [PIX_W-1:0]         o_pixel,
    output logic                     o_last
);

    localparam int VEC_W = NUM_PIX * PIX_W;
    localparam int CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;
    logic              beat;

    // The next pixel to emit always sits at the head end of shreg.
`ifdef PISO_VECTOR_LSB_FIRST_EN
    function automatic logic [PIX_W-1:0] head(input logic [VEC_W-1:0] v);
        return v[PIX_W-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] advance(input logic [VEC_W-1:0] v);
        return v >> PIX_W;
    endfunction
`else
    function automatic logic [PIX_W-1:0] head(input logic [VEC_W-1:0] v);
        return v[VEC_W-1 -: PIX_W];
    endfunction

    function automatic logic [VEC_W-1:0] advance(input logic [VEC_W-1:0] v);
        return v << PIX_W;
    endfunction
`endif

    // A final beat taken together with a new vector lets the next vector follow with no bubble.
    assign o_ready = (state == IDLE) || (o_last && i_ready);
    assign accept  = i_valid && o_ready;
    assign beat    = o_valid && i_ready;
    assign cnt_nxt = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= advance(i_vector);
            cnt     <= '0;
            o_valid <= 1'b1;
            o_pixel <= head(i_vector);
            o_last  <= (LAST_CNT == '0);
        end else if (beat) begin
            if (o_last) begin
                state   <= IDLE;
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end else begin
                shreg   <= advance(shreg);
                cnt     <= cnt_nxt;
                o_pixel <= head(shreg);
                o_last  <= (cnt_nxt == LAST_CNT);
            end
        end
    end

endmodule

// File: tb/tb_piso_vector.sv
// Bench for piso_vector: queue-based reference model, SIPO round-trip window, directed and random stimulus.
module tb_piso_vector;

    localparam int NUM_PIX = 5;
    localparam int PIX_W   = 8;
    localparam int VEC_W   = NUM_PIX * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b0;
    logic [VEC_W-1:0] i_vector = '0;
    logic             o_ready;
    logic             o_valid;
    logic [PIX_W-1:0] o_pixel;
    logic             o_last;

    piso_vector #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_vector (i_vector),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_pixel  (o_pixel),
        .o_last   (o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             last;
    } beat_t;

    int               n_chk  = 0;
    int               n_pass = 0;
    int               cyc    = 0;
    beat_t            exp_q[$];
    logic [VEC_W-1:0] sent_q[$];
    logic [VEC_W-1:0] win = '0;
    logic [PIX_W-1:0] log_pix[$];
    int               log_cyc[$];
    logic             m_acc;
    logic             m_bt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Model: pixels still owed downstream, in emission order.
    function automatic logic model_valid();
        return exp_q.size() > 0;
    endfunction

    function automatic logic model_ready();
        return (exp_q.size() == 0) || (exp_q.size() == 1 && i_ready);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            sent_q.delete();
        end else begin
            m_acc = i_valid && model_ready();
            m_bt  = model_valid() && i_ready;
            if (m_bt) void'(exp_q.pop_front());
            if (m_acc) begin
                sent_q.push_back(i_vector);
                for (int j = 0; j < NUM_PIX; j++) begin
                    beat_t b;
`ifdef PISO_VECTOR_LSB_FIRST_EN
                    b.pix = i_vector[j*PIX_W +: PIX_W];
`else
                    b.pix = i_vector[(NUM_PIX-1-j)*PIX_W +: PIX_W];
`endif
                    b.last = (j == NUM_PIX - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("o_valid", 64'(o_valid), 64'(model_valid()));
            chk("o_ready", 64'(o_ready), 64'(model_ready()));
            if (model_valid()) begin
                chk("o_pixel", 64'(o_pixel), 64'(exp_q[0].pix));
                chk("o_last", 64'(o_last), 64'(exp_q[0].last));
            end
            if (o_valid && i_ready) begin
                log_pix.push_back(o_pixel);
                log_cyc.push_back(cyc);
`ifdef PISO_VECTOR_LSB_FIRST_EN
                win = {o_pixel, win[VEC_W-1:PIX_W]};
`else
                win = {win[VEC_W-PIX_W-1:0], o_pixel};
`endif
                if (o_last) begin
                    if (sent_q.size() > 0) chk("roundtrip", 64'(win), 64'(sent_q.pop_front()));
                    else begin
                        n_chk++;
                        $display("FAIL roundtrip: last beat with no vector outstanding");
                    end
                end
            end
        end
    end

    task automatic clear_log();
        @(posedge clk);
        #1;
        log_pix.delete();
        log_cyc.delete();
    endtask

    task automatic send_vec(input logic [VEC_W-1:0] v);
        int g = 0;
        i_valid  = 1'b1;
        i_vector = v;
        do begin
            @(negedge clk);
            g++;
        end while (!o_ready && g < 50);
        if (!o_ready) timeout_fail("send_vec");
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (o_valid && g < 100);
        if (o_valid) timeout_fail(name);
    endtask

    // Expected pixels are written left to right in emission order.
    task automatic check_log(input string name, input logic [79:0] flat, input int n);
        chk({name, "_len"}, 64'(log_pix.size()), 64'(n));
        for (int k = 0; k < n && k < log_pix.size(); k++)
            chk($sformatf("%s_pix%0d", name, k), 64'(log_pix[k]), 64'(flat[(n-1-k)*PIX_W +: PIX_W]));
    endtask

    task automatic run_random(input int n_vec);
        int sent = 0;
        int g = 0;
        logic take;
        while (sent < n_vec && g < 20000) begin
            @(negedge clk);
            take = i_valid && o_ready;
            @(posedge clk);
            #1;
            g++;
            if (take) begin
                i_valid = 1'b0;
                sent++;
            end
            if (!i_valid && $urandom_range(0, 3) != 0) begin
                i_valid  = 1'b1;
                i_vector = VEC_W'({$urandom, $urandom});
            end
            i_ready = ($urandom_range(0, 3) != 0);
        end
        if (sent < n_vec) timeout_fail("random_send");
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_idle("random_drain");
    endtask

    logic [79:0] seq_basic;
    logic [79:0] seq_b2b;
    logic [79:0] seq_ee;

    initial begin
`ifdef PISO_VECTOR_LSB_FIRST_EN
        seq_basic = 80'h0102030405;
        seq_b2b   = 80'h0102030405060708090A;
        seq_ee    = 80'hAABBCCDDEE;
`else
        seq_basic = 80'h0504030201;
        seq_b2b   = 80'h05040302010A09080706;
        seq_ee    = 80'hEEDDCCBBAA;
`endif
        #2;
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_pixel", 64'(o_pixel), 64'd0);
        chk("reset_last", 64'(o_last), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;

        clear_log();
        send_vec(40'h0504030201);
        wait_idle("basic");
        check_log("basic", seq_basic, 5);
        chk("basic_idle_valid", 64'(o_valid), 64'd0);
        chk("basic_idle_ready", 64'(o_ready), 64'd1);

        clear_log();
        send_vec(40'h0504030201);
        send_vec(40'h0A09080706);
        wait_idle("b2b");
        check_log("b2b", seq_b2b, 10);
        if (log_cyc.size() == 10) chk("b2b_gap", 64'(log_cyc[9] - log_cyc[0]), 64'd9);

        clear_log();
        send_vec(40'h0504030201);
        begin
            int g = 0;
            while (!(o_valid && o_pixel == 8'h03) && g < 20) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (!(o_valid && o_pixel == 8'h03)) timeout_fail("bp_find");
        end
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_pixel", 64'(o_pixel), 64'h03);
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        wait_idle("bp");
        check_log("bp", seq_basic, 5);

        clear_log();
        send_vec(40'h0504030201);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_pixel", 64'(o_pixel), 64'd0);
        chk("midrst_last", 64'(o_last), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        clear_log();
        send_vec(40'hEEDDCCBBAA);
        wait_idle("after_rst");
        check_log("after_rst", seq_ee, 5);

        run_random(200);
        chk("all_vectors_emitted", 64'(sent_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
